// File: rtl/timer_pkg.sv
// Shared timer definitions for the clock dividers and the clock period monitor.
// Contents:
//   state_t          - period monitor FSM state (IDLE, MEASURE, LOCKED), 2 bits
//   *_DEF constants  - default period, tolerance and timeout for a 1 kHz tick
//                      derived from a 100 MHz system clock
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int CW_DEF      = 26;
    localparam int EXP_CNT_DEF = 100000;
    localparam int TOL_DEF     = 500;
    localparam int LOCK_N_DEF  = 4;
    localparam int TIMEOUT_DEF = 200000;

endpackage

// File: rtl/clk_edge_sync.sv
// Brings an asynchronous divided clock into the clk domain and emits a
// one-cycle pulse per rising edge.
// Build option: DEGLITCH_EN inserts a registered 3-tap majority filter after
// the synchroniser so single-cycle glitches are ignored (two extra cycles of
// latency). Without it every synchronised rise is reported.
// Ports:
//   clk_i    - system clock
//   rst_ni   - asynchronous active-low reset
//   clk_in_i - divided clock under test, asynchronous to clk_i
//   rise_o   - one-cycle pulse per detected rising edge
module clk_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clk_in_i,
    output logic rise_o
);

    logic meta_q;
    logic s_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            s_q    <= 1'b0;
        end else begin
            meta_q <= clk_in_i;
            s_q    <= meta_q;
        end
    end

`ifdef DEGLITCH_EN
    logic t1_q;
    logic t2_q;
    logic filt_q;
    logic filt_qq;

    // Majority of three consecutive samples: a level must persist for at
    // least two cycles before the filtered signal follows it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            t1_q    <= 1'b0;
            t2_q    <= 1'b0;
            filt_q  <= 1'b0;
            filt_qq <= 1'b0;
        end else begin
            t1_q    <= s_q;
            t2_q    <= t1_q;
            filt_q  <= (s_q & t1_q) | (s_q & t2_q) | (t1_q & t2_q);
            filt_qq <= filt_q;
        end
    end

    assign rise_o = filt_q & ~filt_qq;
`else
    logic s_qq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_qq <= 1'b0;
        end else begin
            s_qq <= s_q;
        end
    end

    assign rise_o = s_q & ~s_qq;
`endif

endmodule

// File: rtl/clock_period_monitor.sv
// Measures the period of a divided clock (clk_in) in system clock cycles,
// declares lock after LOCK_N consecutive in-tolerance periods and reports
// loss when no rising edge arrives for TIMEOUT cycles.
// Build option: DEGLITCH_EN enables the majority glitch filter in
// clk_edge_sync (rise-to-strobe latency 5 clk instead of 3).
// Ports:
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   clk_in       - divided clock under test, asynchronous to clk
//   period       - last measured period in clk cycles
//   period_valid - one-cycle strobe when period is updated
//   in_tol       - last measured period was within TOL of EXP_CNT
//   locked       - high while in the LOCKED state (one cycle behind the FSM)
//   loss_pulse   - one-cycle strobe when edges stop arriving
module clock_period_monitor
    import timer_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int EXP_CNT = EXP_CNT_DEF,
    parameter int TOL     = TOL_DEF,
    parameter int LOCK_N  = LOCK_N_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_in,
    output logic [CW-1:0] period,
    output logic          period_valid,
    output logic          in_tol,
    output logic          locked,
    output logic          loss_pulse
);

    localparam int GW = $clog2(LOCK_N + 1);

    // Unsigned distance check with one spare bit so cnt+1 cannot wrap.
    function automatic logic within_tol(input logic [CW:0] p);
        logic [CW:0] e;
        logic [CW:0] t;
        e = (CW+1)'(EXP_CNT);
        t = (CW+1)'(TOL);
        if (p >= e) begin
            return (p - e) <= t;
        end else begin
            return (e - p) <= t;
        end
    endfunction

    logic          rise;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [GW-1:0] good_q;
    logic [CW-1:0] period_q;
    logic          pv_q;
    logic          in_tol_q;
    logic          locked_q;
    logic          loss_q;
    logic [CW:0]   meas;
    logic          meas_ok;
    logic          timeout;

    clk_edge_sync u_sync (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clk_in_i (clk_in),
        .rise_o   (rise)
    );

    // A rise at cnt==k closes a period of k+1 cycles.
    assign meas    = {1'b0, cnt_q} + (CW+1)'(1);
    assign meas_ok = within_tol(meas);
    // A rise on the timeout cycle is a valid (long) period, not a loss.
    assign timeout = (state_q != IDLE) && !rise && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            good_q   <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            in_tol_q <= 1'b0;
            locked_q <= 1'b0;
            loss_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pv_q     <= 1'b0;
            loss_q   <= 1'b0;
            // Follows the state one cycle late so lock is seen after the strobe.
            locked_q <= (state_q == LOCKED);
            unique case (state_q)
                IDLE: begin
                    // First edge only starts a measurement window.
                    if (rise) begin
                        state_q <= MEASURE;
                        good_q  <= '0;
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise) begin
                        period_q <= meas[CW-1:0];
                        pv_q     <= 1'b1;
                        in_tol_q <= meas_ok;
                        if (!meas_ok) begin
                            good_q  <= '0;
                            state_q <= MEASURE;
                        end else if (state_q == MEASURE) begin
                            if (good_q == GW'(LOCK_N - 1)) begin
                                good_q  <= GW'(LOCK_N);
                                state_q <= LOCKED;
                            end else begin
                                good_q <= good_q + GW'(1);
                            end
                        end
                    end else if (timeout) begin
                        state_q  <= IDLE;
                        loss_q   <= 1'b1;
                        good_q   <= '0;
                        in_tol_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign in_tol       = in_tol_q;
    assign locked       = locked_q;
    assign loss_pulse   = loss_q;

endmodule

// File: tb/tb_clock_period_monitor.sv
module tb_clock_period_monitor;

    localparam int CW      = 16;
    localparam int EXP_CNT = 100;
    localparam int TOL     = 5;
    localparam int LOCK_N  = 4;
    localparam int TIMEOUT = 200;
`ifdef DEGLITCH_EN
    localparam int LAT = 5;
    localparam bit DG  = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit DG  = 1'b0;
`endif
    localparam int NV = 34;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_in;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          in_tol;
    logic          locked;
    logic          loss_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int hi;        // cycles clk_in is high after the rise
        int lo;        // cycles clk_in is low afterwards
        bit valid;     // strobe expected LAT cycles after the rise
        int per;       // expected measured period (previous record length)
        bit tol;       // expected in_tol
        bit lk_at;     // locked at the strobe sample
        bit lk_after;  // locked one cycle later
    } vec_t;

    vec_t vecs[NV];

    clock_period_monitor #(
        .CW      (CW),
        .EXP_CNT (EXP_CNT),
        .TOL     (TOL),
        .LOCK_N  (LOCK_N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_in       (clk_in),
        .period       (period),
        .period_valid (period_valid),
        .in_tol       (in_tol),
        .locked       (locked),
        .loss_pulse   (loss_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clk_in period starting with a rise at the current negedge.
    task automatic run_vec(input int k);
        vec_t v;
        int   npv;
        int   nloss;
        v     = vecs[k];
        npv   = 0;
        nloss = 0;
        clk_in = 1'b1;
        for (int i = 1; i <= v.hi + v.lo; i++) begin
            @(negedge clk);
            if (period_valid) npv++;
            if (loss_pulse) nloss++;
            if (i == LAT) begin
                check($sformatf("r%0d valid", k), period_valid, v.valid);
                if (v.valid) begin
                    check($sformatf("r%0d period", k), period, v.per);
                    check($sformatf("r%0d in_tol", k), in_tol, v.tol);
                end
                check($sformatf("r%0d locked_at", k), locked, v.lk_at);
            end
            if (i == LAT + 1) check($sformatf("r%0d locked_after", k), locked, v.lk_after);
            if (i == v.hi) clk_in = 1'b0;
        end
        check($sformatf("r%0d strobes", k), npv, v.valid);
        check($sformatf("r%0d loss", k), nloss, 0);
    endtask

    task automatic run_range(input int first, input int last);
        for (int k = first; k <= last; k++) run_vec(k);
    endtask

    // clk_in held low after a locked period: exactly one loss pulse.
    task automatic loss_seq();
        int nloss;
        int npv;
        int loss_idx;
        nloss    = 0;
        npv      = 0;
        loss_idx = -1;
        check("pre_loss locked", locked, 1);
        for (int i = 101; i <= LAT + TIMEOUT + 300; i++) begin
            @(negedge clk);
            if (loss_pulse) begin
                nloss++;
                loss_idx = i;
            end
            if (period_valid) npv++;
        end
        check("loss count", nloss, 1);
        check("loss index", loss_idx, LAT + TIMEOUT);
        check("loss strobes", npv, 0);
        check("loss locked", locked, 0);
        check("loss period held", period, 100);
        check("loss in_tol", in_tol, 0);
    endtask

    // Asynchronous reset while locked clears everything at once.
    task automatic reset_seq();
        check("pre_rst locked", locked, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst locked", locked, 0);
        check("rst period", period, 0);
        check("rst period_valid", period_valid, 0);
        check("rst in_tol", in_tol, 0);
        check("rst loss_pulse", loss_pulse, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single-cycle high glitch 75 cycles into a 100-cycle period.
    task automatic glitch_seq();
        int npv;
        npv    = 0;
        clk_in = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (period_valid) npv++;
            if (i == LAT) begin
                check("glitch main valid", period_valid, 1);
                check("glitch main period", period, 100);
                check("glitch main in_tol", in_tol, 1);
            end
`ifndef DEGLITCH_EN
            if (i == 75 + LAT) begin
                check("glitch valid", period_valid, 1);
                check("glitch period", period, 75);
                check("glitch in_tol", in_tol, 0);
            end
`endif
            if (i == 50) clk_in = 1'b0;
            else if (i == 75) clk_in = 1'b1;
            else if (i == 76) clk_in = 1'b0;
        end
        check("glitch strobes", npv, DG ? 1 : 2);
    endtask

    initial begin
        //            hi  lo  vld per  tol at after
        vecs[0]  = '{50, 50, 0, 0,   0, 0, 0};   // arm only
        vecs[1]  = '{50, 50, 1, 100, 1, 0, 0};
        vecs[2]  = '{50, 50, 1, 100, 1, 0, 0};
        vecs[3]  = '{50, 50, 1, 100, 1, 0, 0};
        vecs[4]  = '{50, 50, 1, 100, 1, 0, 1};   // 4th good -> lock
        vecs[5]  = '{50, 50, 1, 100, 1, 1, 1};
        vecs[6]  = '{53, 53, 1, 100, 1, 1, 1};   // slow period follows
        vecs[7]  = '{50, 50, 1, 106, 0, 1, 0};   // bad -> unlock
        vecs[8]  = '{50, 50, 1, 100, 1, 0, 0};
        vecs[9]  = '{50, 50, 1, 100, 1, 0, 0};
        vecs[10] = '{50, 50, 1, 100, 1, 0, 0};
        vecs[11] = '{50, 50, 1, 100, 1, 0, 1};   // relock
        vecs[12] = '{50, 50, 1, 100, 1, 1, 1};
        vecs[13] = '{52, 53, 1, 100, 1, 1, 1};   // 105 follows
        vecs[14] = '{47, 47, 1, 105, 1, 1, 1};   // +TOL edge is good
        vecs[15] = '{47, 48, 1, 94,  0, 1, 0};   // -TOL-1 is bad
        vecs[16] = '{50, 50, 1, 95,  1, 0, 0};   // -TOL edge is good
        vecs[17] = '{50, 50, 1, 100, 1, 0, 0};
        vecs[18] = '{50, 50, 1, 100, 1, 0, 0};
        vecs[19] = '{50, 50, 1, 100, 1, 0, 1};
        vecs[20] = '{50, 150, 1, 100, 1, 1, 1};  // next rise lands on timeout
        vecs[21] = '{50, 50, 1, 200, 0, 1, 0};
        vecs[22] = '{50, 50, 1, 100, 1, 0, 0};
        vecs[23] = '{50, 50, 1, 100, 1, 0, 0};
        vecs[24] = '{50, 50, 1, 100, 1, 0, 0};
        vecs[25] = '{50, 50, 1, 100, 1, 0, 1};
        vecs[26] = '{50, 50, 0, 0,   0, 0, 0};   // re-arm from IDLE
        vecs[27] = '{50, 50, 1, 100, 1, 0, 0};
        vecs[28] = '{50, 50, 1, 100, 1, 0, 0};
        vecs[29] = '{50, 50, 1, 100, 1, 0, 0};
        vecs[30] = '{50, 50, 1, 100, 1, 0, 1};
        vecs[31] = '{50, 50, 0, 0,   0, 0, 0};   // first rise after reset
        vecs[32] = '{50, 50, 1, 100, 1, 0, 0};
        vecs[33] = '{50, 50, 1, DG ? 100 : 25, DG ? 1'b1 : 1'b0, 0, 0};

        rst_n  = 1'b0;
        clk_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset period", period, 0);
        check("reset period_valid", period_valid, 0);
        check("reset in_tol", in_tol, 0);
        check("reset locked", locked, 0);
        check("reset loss_pulse", loss_pulse, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_range(0, 25);
        loss_seq();
        run_range(26, 30);
        reset_seq();
        run_range(31, 32);
        glitch_seq();
        run_range(33, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
